// File: rtl/relay_pkg.sv
// Shared constants for the single-wire relay link (transmit and receive sides).
// Holds bit timing, line levels and the transmitter state encoding.
package relay_pkg;

   localparam int   RELAY_SAMPLES_PER_BIT = 32;
   localparam int   RELAY_DATA_BITS       = 8;
   localparam logic RELAY_START_LEVEL     = 1'b1;
   localparam logic RELAY_IDLE_LEVEL      = 1'b0;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/relay_fifo.sv
// Small synchronous FIFO with count; read data comes straight from the storage flops.
// Pushes while full and pops while empty are dropped.
module relay_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == CW'(0));
   assign count     = count_q;
   assign rd_data   = mem_q[rd_ptr_q];
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/relay_transmit.sv
// Relay link transmitter: buffers bytes and sends start bit plus MSB-first data,
// each bit held SAMPLES_PER_BIT clocks; consecutive frames are sent without a gap.
module relay_transmit
   import relay_pkg::*;
#(
   parameter int SAMPLES_PER_BIT = RELAY_SAMPLES_PER_BIT,
   parameter int DATA_BITS       = RELAY_DATA_BITS,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 data_out,
   output logic                 busy
);

   localparam int SCW = $clog2(SAMPLES_PER_BIT);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e            state_q, state_d;
   logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 data_out_q, data_out_d;
   logic                 push_s, pop_s;
   logic                 sample_last_s, bit_last_s;
   logic [DATA_BITS-1:0] fifo_rd_data_s;
   logic                 fifo_full_s, fifo_empty_s;
   logic [FCW-1:0]       fifo_count_s;

   relay_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_s),
      .wr_data (data_in),
      .pop     (pop_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   assign data_ready    = !reset && !fifo_full_s;
   assign push_s        = data_valid && data_ready;
   assign busy          = (state_q != TX_IDLE) || (fifo_count_s != FCW'(0));
   assign data_out      = data_out_q;
   assign sample_last_s = (sample_cnt_q == SCW'(SAMPLES_PER_BIT - 1));
   assign bit_last_s    = (bit_cnt_q == BCW'(DATA_BITS - 1));

   // Frame sequencing; the line level is computed for the state being entered.
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      pop_s        = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s        = 1'b1;
               shift_d      = fifo_rd_data_s;
               bit_cnt_d    = BCW'(0);
               sample_cnt_d = SCW'(0);
               state_d      = TX_START;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (sample_last_s) begin
               sample_cnt_d = SCW'(0);
               state_d      = TX_DATA;
            end else begin
               sample_cnt_d = sample_cnt_q + SCW'(1);
            end
         end
         TX_DATA: begin
            if (sample_last_s) begin
               sample_cnt_d = SCW'(0);
               shift_d      = {shift_q[DATA_BITS-2:0], 1'b0};
               bit_cnt_d    = bit_cnt_q + BCW'(1);
               if (bit_last_s) begin
                  bit_cnt_d = BCW'(0);
                  // Chain straight into the next start bit when more data is waiting.
                  if (!fifo_empty_s) begin
                     pop_s   = 1'b1;
                     shift_d = fifo_rd_data_s;
                     state_d = TX_START;
                  end else begin
                     state_d = TX_IDLE;
                  end
               end else begin
                  state_d = TX_DATA;
               end
            end else begin
               sample_cnt_d = sample_cnt_q + SCW'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
      case (state_d)
         TX_START: data_out_d = RELAY_START_LEVEL;
         TX_DATA:  data_out_d = shift_d[DATA_BITS-1];
         default:  data_out_d = RELAY_IDLE_LEVEL;
      endcase
   end

   // State, counters, shift register and line register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= TX_IDLE;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= RELAY_IDLE_LEVEL;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
      end
   end

endmodule

// File: tb/tb_relay_transmit.sv
// Directed bench for relay_transmit: frame timing tables, back-to-back, FIFO full,
// mid-frame reset and a loopback through a majority-vote receiver model.
module tb_relay_transmit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       data_out;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   relay_transmit dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_out   (data_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model: 32-sample majority vote per bit, start bit opens a frame.
   logic       rx_active = 1'b0;
   int         rx_cnt    = 0;
   int         rx_ones   = 0;
   int         rx_bit    = 0;
   logic [7:0] rx_shift  = 8'h00;
   logic [7:0] rx_mem [0:63];
   int         rx_n      = 0;
   int         rx_bad_start = 0;
   logic       rx_vote_s;

   assign rx_vote_s = (rx_ones + (data_out ? 1 : 0)) >= 16;

   always @(posedge clk) begin
      if (reset) begin
         rx_active <= 1'b0;
         rx_cnt    <= 0;
         rx_ones   <= 0;
         rx_bit    <= 0;
      end else if (!rx_active) begin
         if (data_out) begin
            rx_active <= 1'b1;
            rx_cnt    <= 1;
            rx_ones   <= 1;
            rx_bit    <= 0;
         end
      end else if (rx_cnt == 31) begin
         if (rx_bit == 0) begin
            if (!rx_vote_s) rx_bad_start <= rx_bad_start + 1;
         end else begin
            rx_shift <= {rx_shift[6:0], rx_vote_s};
         end
         if (rx_bit == 8) begin
            if (rx_n < 64) rx_mem[rx_n] <= {rx_shift[6:0], rx_vote_s};
            rx_n      <= rx_n + 1;
            rx_active <= 1'b0;
         end
         rx_bit  <= rx_bit + 1;
         rx_cnt  <= 0;
         rx_ones <= 0;
      end else begin
         rx_cnt  <= rx_cnt + 1;
         rx_ones <= rx_ones + (data_out ? 1 : 0);
      end
   end

   typedef struct packed {
      logic [7:0] din;
      logic [8:0] frame;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_window(input logic lvl, input int len, input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < len; i++) begin
         if (data_out !== lvl || busy !== 1'b1) bad++;
         tick();
      end
      check(name, bad, 0);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n;
      n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
   endtask

   task automatic push_one(input logic [7:0] b, input string name);
      data_in    = b;
      data_valid = 1'b1;
      check(name, {31'd0, data_ready}, 32'd1);
      tick();
      data_valid = 1'b0;
   endtask

   initial begin
      int         e0;
      int         base;
      int         n;
      int         bad;
      logic [26:0] stream;
      logic [7:0]  sent [16];

      vecs[0] = '{din: 8'hA5, frame: 9'b1_1010_0101};
      vecs[1] = '{din: 8'h3C, frame: 9'b1_0011_1100};
      vecs[2] = '{din: 8'h01, frame: 9'b1_0000_0001};
      vecs[3] = '{din: 8'hC3, frame: 9'b1_1100_0011};

      reset      = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;
      tick();
      tick();
      check("reset_ready_low", {31'd0, data_ready}, 32'd0);
      check("reset_line_low",  {31'd0, data_out}, 32'd0);
      check("reset_busy_low",  {31'd0, busy}, 32'd0);
      reset = 1'b0;
      #1;
      check("post_reset_ready", {31'd0, data_ready}, 32'd1);
      for (int i = 0; i < 7; i++) tick();

      // Single frames from the table.
      for (int v = 0; v < 4; v++) begin
         base = rx_n;
         push_one(vecs[v].din, $sformatf("v%0d_ready", v));
         check($sformatf("v%0d_line_before_pop", v), {31'd0, data_out}, 32'd0);
         check($sformatf("v%0d_busy_rise", v), {31'd0, busy}, 32'd1);
         tick();
         for (int k = 8; k >= 0; k--)
            expect_window(vecs[v].frame[k], 32, $sformatf("v%0d_bit%0d", v, k));
         check($sformatf("v%0d_line_after", v), {31'd0, data_out}, 32'd0);
         check($sformatf("v%0d_busy_fall", v), {31'd0, busy}, 32'd0);
         check($sformatf("v%0d_rx_count", v), rx_n - base, 1);
         check($sformatf("v%0d_rx_byte", v), {24'd0, rx_mem[base]}, {24'd0, vecs[v].din});
         for (int i = 0; i < 5; i++) tick();
      end

      // Back-to-back frames on consecutive pushes.
      base   = rx_n;
      stream = 27'b1_11111111_1_00000000_1_10000001;
      push_one(8'hFF, "b2b_push0");
      push_one(8'h00, "b2b_push1");
      push_one(8'h81, "b2b_push2");
      expect_window(stream[26], 31, "b2b_bit26");
      for (int k = 25; k >= 0; k--)
         expect_window(stream[k], 32, $sformatf("b2b_bit%0d", k));
      check("b2b_line_after", {31'd0, data_out}, 32'd0);
      check("b2b_busy_fall",  {31'd0, busy}, 32'd0);
      check("b2b_rx_count", rx_n - base, 3);
      check("b2b_rx0", {24'd0, rx_mem[base]},     32'h000000FF);
      check("b2b_rx1", {24'd0, rx_mem[base + 1]}, 32'h00000000);
      check("b2b_rx2", {24'd0, rx_mem[base + 2]}, 32'h00000081);
      for (int i = 0; i < 5; i++) tick();

      // Fill the FIFO while a frame is on the wire; a rejected 3C must vanish.
      base = rx_n;
      push_one(8'h11, "fill_push11");
      e0 = cyc;
      for (int i = 0; i < 5; i++) tick();
      push_one(8'h22, "fill_push22");
      push_one(8'h33, "fill_push33");
      push_one(8'h44, "fill_push44");
      push_one(8'h55, "fill_push55");
      check("fill_ready_low", {31'd0, data_ready}, 32'd0);
      data_in    = 8'h3C;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      data_in    = 8'h66;
      data_valid = 1'b1;
      n = 0;
      while (!data_ready && n < 400) begin
         tick();
         n++;
      end
      check("fill_ready_back", {31'd0, data_ready}, 32'd1);
      check("fill_ready_cycle", cyc, e0 + 289);
      tick();
      data_valid = 1'b0;
      wait_idle(3000, "fill_idle_timeout");
      check("fill_rx_count", rx_n - base, 6);
      check("fill_rx0", {24'd0, rx_mem[base]},     32'h00000011);
      check("fill_rx1", {24'd0, rx_mem[base + 1]}, 32'h00000022);
      check("fill_rx2", {24'd0, rx_mem[base + 2]}, 32'h00000033);
      check("fill_rx3", {24'd0, rx_mem[base + 3]}, 32'h00000044);
      check("fill_rx4", {24'd0, rx_mem[base + 4]}, 32'h00000055);
      check("fill_rx5", {24'd0, rx_mem[base + 5]}, 32'h00000066);
      for (int i = 0; i < 5; i++) tick();

      // Reset 100 samples into a frame with two bytes queued.
      base = rx_n;
      push_one(8'hAA, "rst_push0");
      e0 = cyc;
      push_one(8'hBB, "rst_push1");
      push_one(8'hCC, "rst_push2");
      while (cyc < e0 + 101) tick();
      check("rst_mid_frame_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("rst_ready_low", {31'd0, data_ready}, 32'd0);
      tick();
      check("rst_line_low", {31'd0, data_out}, 32'd0);
      check("rst_busy_low", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         if (data_out !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      check("rst_no_residual", bad, 0);
      check("rst_rx_none", rx_n - base, 0);

      // Loopback stream of random bytes through the receiver model.
      base = rx_n;
      for (int i = 0; i < 16; i++) sent[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) begin
         data_in    = sent[i];
         data_valid = 1'b1;
         n = 0;
         while (!data_ready && n < 1000) begin
            tick();
            n++;
         end
         check($sformatf("loop_ready%0d", i), {31'd0, data_ready}, 32'd1);
         tick();
      end
      data_valid = 1'b0;
      wait_idle(6000, "loop_idle_timeout");
      check("loop_rx_count", rx_n - base, 16);
      for (int i = 0; i < 16; i++)
         check($sformatf("loop_rx%0d", i), {24'd0, rx_mem[base + i]}, {24'd0, sent[i]});
      check("rx_start_bits", rx_bad_start, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
